// File: rtl/audio_tune_sequencer.sv
// audio_tune_sequencer
// Melody player for the game FSM. When the FSM raises audio_enable, the block
// latches audio_select and walks through a fixed tune ROM. It drives a
// square-wave tone on pwm_pin and the amplifier enable on amp_pin. When a
// tune ends normally it pulses seq_end for one cycle. The tune then waits
// for audio_enable to drop before it can be played again.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   audio_enable level request: high = play, low = stop / re-arm
//   audio_select tune number, sampled only when a tune starts
//   seq_end      one-cycle pulse when a tune finishes normally
//   pwm_pin      square-wave tone output
//   amp_pin      amplifier enable, high while a note or rest is timing
//   busy         high whenever the sequencer is not idle
//   note_idx     current ROM entry index (debug)
//
// Build option:
//   SEQ_LOOP_EN  when defined, the end of a tune pulses seq_end and restarts
//                the tune at entry 0 for as long as audio_enable stays high.

module audio_tune_sequencer #(
    parameter int CLK_FREQ   = 100000000,
    parameter int TICK_DIV   = 1250000,
    parameter int GAP_CYCLES = 250000,
    parameter int SEQ_LEN    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       audio_enable,
    input  logic [2:0] audio_select,
    output logic       seq_end,
    output logic       pwm_pin,
    output logic       amp_pin,
    output logic       busy,
    output logic [3:0] note_idx
);

    localparam int TICK_W = $clog2(TICK_DIV + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    // Half-period in clock cycles, rounded to nearest, for a frequency in mHz.
    // Integer arithmetic keeps this usable as an elaboration-time constant.
    function automatic logic [17:0] half_of(input longint f_mhz);
        longint num;
        longint den;
        num = longint'(CLK_FREQ) * 64'sd1000 + f_mhz;
        den = 64'sd2 * f_mhz;
        return 18'(num / den);
    endfunction

    localparam logic [17:0] HP_C5  = half_of(64'sd523251);
    localparam logic [17:0] HP_CS5 = half_of(64'sd554365);
    localparam logic [17:0] HP_D5  = half_of(64'sd587330);
    localparam logic [17:0] HP_DS5 = half_of(64'sd622254);
    localparam logic [17:0] HP_E5  = half_of(64'sd659255);
    localparam logic [17:0] HP_F5  = half_of(64'sd698456);
    localparam logic [17:0] HP_FS5 = half_of(64'sd739989);
    localparam logic [17:0] HP_G5  = half_of(64'sd783991);
    localparam logic [17:0] HP_GS5 = half_of(64'sd830609);
    localparam logic [17:0] HP_A5  = half_of(64'sd880000);
    localparam logic [17:0] HP_AS5 = half_of(64'sd932328);
    localparam logic [17:0] HP_B5  = half_of(64'sd987767);
    localparam logic [17:0] HP_C6  = half_of(64'sd1046502);
    localparam logic [17:0] HP_E6  = half_of(64'sd1318510);

    // Note code to half-period. Rest (0) and end (15) never produce a tone.
    function automatic logic [17:0] half_lookup(input logic [3:0] code);
        logic [17:0] hp;
        case (code)
            4'd1:    hp = HP_C5;
            4'd2:    hp = HP_CS5;
            4'd3:    hp = HP_D5;
            4'd4:    hp = HP_DS5;
            4'd5:    hp = HP_E5;
            4'd6:    hp = HP_F5;
            4'd7:    hp = HP_FS5;
            4'd8:    hp = HP_G5;
            4'd9:    hp = HP_GS5;
            4'd10:   hp = HP_A5;
            4'd11:   hp = HP_AS5;
            4'd12:   hp = HP_B5;
            4'd13:   hp = HP_C6;
            4'd14:   hp = HP_E6;
            default: hp = '0;
        endcase
        return hp;
    endfunction

    // Tune ROM: each entry is {code, duration in ticks}. Unlisted entries
    // hold the end marker, so any tune stops cleanly past its last note.
    function automatic logic [7:0] rom_entry(input logic [2:0] sel, input logic [3:0] idx);
        logic [7:0] e;
        e = 8'hF0;
        case (sel)
            3'd0: case (idx)
                4'd0: e = 8'h12;
                4'd1: e = 8'h52;
                4'd2: e = 8'h82;
                4'd3: e = 8'hD4;
                default: e = 8'hF0;
            endcase
            3'd1: case (idx)
                4'd0: e = 8'h82;
                4'd1: e = 8'h52;
                4'd2: e = 8'h16;
                default: e = 8'hF0;
            endcase
            3'd2: case (idx)
                4'd0: e = 8'h11;
                4'd1: e = 8'h31;
                4'd2: e = 8'h51;
                4'd3: e = 8'h81;
                4'd4: e = 8'hD3;
                default: e = 8'hF0;
            endcase
            3'd3: case (idx)
                4'd0: e = 8'hA1;
                4'd1: e = 8'h01;
                4'd2: e = 8'hA1;
                default: e = 8'hF0;
            endcase
            3'd4: case (idx)
                4'd0: e = 8'hC1;
                4'd1: e = 8'hE3;
                default: e = 8'hF0;
            endcase
            3'd5: case (idx)
                4'd0: e = 8'h82;
                4'd1: e = 8'h02;
                4'd2: e = 8'h82;
                4'd3: e = 8'h02;
                default: e = 8'hF0;
            endcase
            3'd6: case (idx)
                4'd0: e = 8'h12;
                4'd1: e = 8'h12;
                4'd2: e = 8'h12;
                4'd3: e = 8'h56;
                4'd4: e = 8'h32;
                4'd5: e = 8'h52;
                4'd6: e = 8'hD8;
                default: e = 8'hF0;
            endcase
            default: e = 8'hF0;
        endcase
        return e;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          sel_q, sel_d;
    logic [3:0]          note_idx_q, note_idx_d;
    logic                rest_q, rest_d;
    logic [17:0]         half_q, half_d;
    logic [3:0]          dur_q, dur_d;
    logic [17:0]         tone_cnt_q, tone_cnt_d;
    logic                tone_lvl_q, tone_lvl_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                armed_q, armed_d;
    logic                seq_end_q, seq_end_d;
    logic                pwm_q, pwm_d;
    logic                amp_q, amp_d;
    logic                busy_q, busy_d;

    logic [7:0]          entry;
    logic                at_last;
    logic                tune_over;

    // Next-state and next-output logic. The audio pins are registered from
    // the current PLAY cycle, so they trail the state by one edge. An abort
    // forces them low on the abort edge itself. seq_end and busy follow the
    // next state, so they change on the same edge as the transition.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        note_idx_d = note_idx_q;
        rest_d     = rest_q;
        half_d     = half_q;
        dur_d      = dur_q;
        tone_cnt_d = tone_cnt_q;
        tone_lvl_d = tone_lvl_q;
        tick_cnt_d = tick_cnt_q;
        gap_cnt_d  = '0;
        armed_d    = armed_q;
        seq_end_d  = 1'b0;
        pwm_d      = 1'b0;
        amp_d      = 1'b0;
        tune_over  = 1'b0;
        entry      = rom_entry(sel_q, note_idx_q);
        at_last    = (note_idx_q == 4'(SEQ_LEN - 1));

        case (state_q)
            S_IDLE: begin
                if (audio_enable && armed_q) begin
                    sel_d      = audio_select;
                    note_idx_d = 4'd0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!audio_enable) begin
                    state_d    = S_IDLE;
                    armed_d    = 1'b1;
                    note_idx_d = 4'd0;
                end else if (entry[7:4] == 4'hF) begin
                    tune_over = 1'b1;
                end else begin
                    rest_d     = (entry[7:4] == 4'd0);
                    half_d     = half_lookup(entry[7:4]);
                    dur_d      = (entry[3:0] == 4'd0) ? 4'd1 : entry[3:0];
                    tone_cnt_d = '0;
                    tone_lvl_d = 1'b1;
                    tick_cnt_d = '0;
                    state_d    = S_PLAY;
                end
            end
            S_PLAY: begin
                if (!audio_enable) begin
                    state_d    = S_IDLE;
                    armed_d    = 1'b1;
                    note_idx_d = 4'd0;
                end else begin
                    amp_d = 1'b1;
                    pwm_d = !rest_q && tone_lvl_q;
                    if (tone_cnt_q == half_q - 18'd1) begin
                        tone_cnt_d = '0;
                        tone_lvl_d = !tone_lvl_q;
                    end else begin
                        tone_cnt_d = tone_cnt_q + 18'd1;
                    end
                    // The duration counts down once per tick wrap. The note
                    // ends on the wrap that consumes the last tick.
                    if (tick_cnt_q == TICK_W'(TICK_DIV - 1)) begin
                        tick_cnt_d = '0;
                        if (dur_q == 4'd1) begin
                            state_d = S_GAP;
                        end else begin
                            dur_d = dur_q - 4'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (!audio_enable) begin
                    state_d    = S_IDLE;
                    armed_d    = 1'b1;
                    note_idx_d = 4'd0;
                end else if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    if (at_last) begin
                        tune_over = 1'b1;
                    end else begin
                        note_idx_d = note_idx_q + 4'd1;
                        state_d    = S_LOAD;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            S_DONE: begin
                if (!audio_enable) begin
                    state_d = S_IDLE;
                    armed_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The end marker and the implicit end after the last ROM slot share
        // one exit path.
        if (tune_over) begin
            seq_end_d = 1'b1;
`ifdef SEQ_LOOP_EN
            note_idx_d = 4'd0;
            state_d    = S_LOAD;
`else
            armed_d = 1'b0;
            state_d = S_DONE;
`endif
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers. The sequencer comes out of reset armed so
    // that the first enable after reset starts a tune.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sel_q      <= 3'd0;
            note_idx_q <= 4'd0;
            rest_q     <= 1'b0;
            half_q     <= '0;
            dur_q      <= 4'd0;
            tone_cnt_q <= '0;
            tone_lvl_q <= 1'b0;
            tick_cnt_q <= '0;
            gap_cnt_q  <= '0;
            armed_q    <= 1'b1;
            seq_end_q  <= 1'b0;
            pwm_q      <= 1'b0;
            amp_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            note_idx_q <= note_idx_d;
            rest_q     <= rest_d;
            half_q     <= half_d;
            dur_q      <= dur_d;
            tone_cnt_q <= tone_cnt_d;
            tone_lvl_q <= tone_lvl_d;
            tick_cnt_q <= tick_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            armed_q    <= armed_d;
            seq_end_q  <= seq_end_d;
            pwm_q      <= pwm_d;
            amp_q      <= amp_d;
            busy_q     <= busy_d;
        end
    end

    assign seq_end  = seq_end_q;
    assign pwm_pin  = pwm_q;
    assign amp_pin  = amp_q;
    assign busy     = busy_q;
    assign note_idx = note_idx_q;

endmodule
